nvdla_axi2dbb_req: RTL and testbench

Initiator-side adapter between the NVDLA primary memory (DBB) AXI-style master port and the single-beat DBB request/data interface (`ctrl_dbb_t` / `flags_dbb_t`) served by the HWPE-side DBB bridge.

- It accepts AW/W/B and AR/R bursts from NVDLA.
- It splits each burst into single-beat requests with incrementing addresses.
- It returns exactly one B per write burst and one R beat per read beat.
- Only one burst is in flight at a time.

---
 rtl/nvdla_axi2dbb_req.sv | 241 ++++++++++++++++++++++++
 tb/tb_nvdla_axi2dbb_req.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nvdla_axi2dbb_req.sv
// NVDLA DBB AXI master to single-beat DBB bridge adapter; one burst in flight at a time.
// Optional round-robin AW/AR arbitration is enabled by defining NVDLA_AXI2DBB_RR_ARB_EN.
package nvdla_axi2dbb_pkg;
  localparam int unsigned DBB_DW  = 512;
  localparam int unsigned DBB_AW  = 64;
  localparam int unsigned DBB_IDW = 8;

  typedef struct packed {
    logic               valid;
    logic [DBB_IDW-1:0] id;
    logic [DBB_AW-1:0]  addr;
  } dbb_req_ctrl_t;

  typedef struct packed {
    logic                valid;
    logic [DBB_DW-1:0]   data;
    logic [DBB_DW/8-1:0] strb;
    logic                last;
  } dbb_wdata_ctrl_t;

  typedef struct packed {
    logic ready;
  } dbb_ready_t;

  typedef struct packed {
    logic valid;
  } dbb_valid_t;

  typedef struct packed {
    logic              valid;
    logic [DBB_DW-1:0] data;
  } dbb_rdata_flags_t;

  typedef struct packed {
    dbb_req_ctrl_t   write_request_ctrl;
    dbb_req_ctrl_t   read_request_ctrl;
    dbb_wdata_ctrl_t write_data_ctrl;
    dbb_ready_t      write_response_ctrl;
    dbb_ready_t      read_data_ctrl;
  } ctrl_dbb_t;

  typedef struct packed {
    dbb_ready_t       write_request_flags;
    dbb_ready_t       read_request_flags;
    dbb_ready_t       write_data_flags;
    dbb_valid_t       write_response_flags;
    dbb_rdata_flags_t read_data_flags;
  } flags_dbb_t;
endpackage

module nvdla_axi2dbb_req
  import nvdla_axi2dbb_pkg::*;
#(
  parameter int unsigned DW  = DBB_DW,
  parameter int unsigned AW  = DBB_AW,
  parameter int unsigned IDW = DBB_IDW
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  input  logic [IDW-1:0]  aw_id_i,
  input  logic [AW-1:0]   aw_addr_i,
  input  logic [3:0]      aw_len_i,
  input  logic            w_valid_i,
  output logic            w_ready_o,
  input  logic [DW-1:0]   w_data_i,
  input  logic [DW/8-1:0] w_strb_i,
  input  logic            w_last_i,
  output logic            b_valid_o,
  input  logic            b_ready_i,
  output logic [IDW-1:0]  b_id_o,
  input  logic            ar_valid_i,
  output logic            ar_ready_o,
  input  logic [IDW-1:0]  ar_id_i,
  input  logic [AW-1:0]   ar_addr_i,
  input  logic [3:0]      ar_len_i,
  output logic            r_valid_o,
  input  logic            r_ready_i,
  output logic [IDW-1:0]  r_id_o,
  output logic [DW-1:0]   r_data_o,
  output logic            r_last_o,
  output ctrl_dbb_t       ctrl_o,
  input  flags_dbb_t      flags_i
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_DATA, WR_RESP, B_RESP, RD_REQ, RD_DATA
  } state_e;

  localparam logic PRIO_WR = 1'b0;
  localparam logic PRIO_RD = 1'b1;

  state_e         state_q, state_d;
  logic [IDW-1:0] id_q;
  logic [AW-1:0]  addr_q;
  logic [3:0]     len_q;
  logic [3:0]     beat_q;
  logic           prio_q;

  logic wr_grant, rd_grant;
  logic capture_wr, capture_rd, advance, done_wr, done_rd;
  logic last_beat;

  // The opposing valid only matters for contention; a lone request is always granted.
`ifdef NVDLA_AXI2DBB_RR_ARB_EN
  assign wr_grant = !ar_valid_i || (prio_q == PRIO_WR);
  assign rd_grant = !aw_valid_i || (prio_q == PRIO_RD);
`else
  assign wr_grant = 1'b1;
  assign rd_grant = !aw_valid_i;
`endif

  assign last_beat = (beat_q == len_q);

  always_comb begin
    state_d    = state_q;
    ctrl_o     = '0;
    aw_ready_o = 1'b0;
    ar_ready_o = 1'b0;
    w_ready_o  = 1'b0;
    b_valid_o  = 1'b0;
    b_id_o     = '0;
    r_valid_o  = 1'b0;
    r_id_o     = '0;
    r_data_o   = '0;
    r_last_o   = 1'b0;
    capture_wr = 1'b0;
    capture_rd = 1'b0;
    advance    = 1'b0;
    done_wr    = 1'b0;
    done_rd    = 1'b0;
    case (state_q)
      IDLE: begin
        // Gated by reset so no address handshake is offered while held in reset.
        aw_ready_o = rst_ni && wr_grant;
        ar_ready_o = rst_ni && rd_grant;
        if (aw_valid_i && aw_ready_o) begin
          capture_wr = 1'b1;
          state_d    = WR_REQ;
        end else if (ar_valid_i && ar_ready_o) begin
          capture_rd = 1'b1;
          state_d    = RD_REQ;
        end
      end
      WR_REQ: begin
        ctrl_o.write_request_ctrl.valid = 1'b1;
        ctrl_o.write_request_ctrl.id    = id_q;
        ctrl_o.write_request_ctrl.addr  = addr_q;
        if (flags_i.write_request_flags.ready) state_d = WR_DATA;
      end
      WR_DATA: begin
        ctrl_o.write_data_ctrl.valid = w_valid_i;
        ctrl_o.write_data_ctrl.data  = w_data_i;
        ctrl_o.write_data_ctrl.strb  = w_strb_i;
        ctrl_o.write_data_ctrl.last  = 1'b1;
        w_ready_o = flags_i.write_data_flags.ready;
        if (w_valid_i && w_ready_o) state_d = WR_RESP;
      end
      WR_RESP: begin
        ctrl_o.write_response_ctrl.ready = 1'b1;
        if (flags_i.write_response_flags.valid) begin
          if (last_beat) begin
            state_d = B_RESP;
          end else begin
            advance = 1'b1;
            state_d = WR_REQ;
          end
        end
      end
      B_RESP: begin
        b_valid_o = 1'b1;
        b_id_o    = id_q;
        if (b_ready_i) begin
          done_wr = 1'b1;
          state_d = IDLE;
        end
      end
      RD_REQ: begin
        ctrl_o.read_request_ctrl.valid = 1'b1;
        ctrl_o.read_request_ctrl.id    = id_q;
        ctrl_o.read_request_ctrl.addr  = addr_q;
        if (flags_i.read_request_flags.ready) state_d = RD_DATA;
      end
      RD_DATA: begin
        ctrl_o.read_data_ctrl.ready = r_ready_i;
        r_valid_o = flags_i.read_data_flags.valid;
        r_data_o  = flags_i.read_data_flags.data;
        r_id_o    = id_q;
        r_last_o  = last_beat;
        if (r_valid_o && r_ready_i) begin
          if (last_beat) begin
            done_rd = 1'b1;
            state_d = IDLE;
          end else begin
            advance = 1'b1;
            state_d = RD_REQ;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Address steps by one full data beat and wraps at 2^AW.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      prio_q  <= PRIO_WR;
    end else begin
      state_q <= state_d;
      if (capture_wr) begin
        id_q   <= aw_id_i;
        addr_q <= aw_addr_i;
        len_q  <= aw_len_i;
        beat_q <= '0;
      end else if (capture_rd) begin
        id_q   <= ar_id_i;
        addr_q <= ar_addr_i;
        len_q  <= ar_len_i;
        beat_q <= '0;
      end else if (advance) begin
        beat_q <= beat_q + 4'd1;
        addr_q <= addr_q + AW'(DW / 8);
      end
`ifdef NVDLA_AXI2DBB_RR_ARB_EN
      if (done_wr) prio_q <= PRIO_RD;
      else if (done_rd) prio_q <= PRIO_WR;
`endif
    end
  end

  // Burst completion is decided by the beat counter, so the NVDLA last flag is not consumed.
  logic unused_sink;
  assign unused_sink = ^{w_last_i, prio_q, done_wr, done_rd};

endmodule

// File: tb/tb_nvdla_axi2dbb_req.sv
// Directed self-checking bench for nvdla_axi2dbb_req with an in-bench DBB bridge driver.
// Arbitration expectations follow NVDLA_AXI2DBB_RR_ARB_EN when it is defined for the build.
module tb_nvdla_axi2dbb_req;
  import nvdla_axi2dbb_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic         aw_valid_i = 1'b0, aw_ready_o;
  logic [7:0]   aw_id_i = '0;
  logic [63:0]  aw_addr_i = '0;
  logic [3:0]   aw_len_i = '0;
  logic         w_valid_i = 1'b0, w_ready_o;
  logic [511:0] w_data_i = '0;
  logic [63:0]  w_strb_i = '0;
  logic         w_last_i = 1'b0;
  logic         b_valid_o, b_ready_i = 1'b0;
  logic [7:0]   b_id_o;
  logic         ar_valid_i = 1'b0, ar_ready_o;
  logic [7:0]   ar_id_i = '0;
  logic [63:0]  ar_addr_i = '0;
  logic [3:0]   ar_len_i = '0;
  logic         r_valid_o, r_ready_i = 1'b0;
  logic [7:0]   r_id_o;
  logic [511:0] r_data_o;
  logic         r_last_o;
  ctrl_dbb_t    ctrl_o;
  flags_dbb_t   flags_i = '0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  nvdla_axi2dbb_req dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .aw_valid_i(aw_valid_i), .aw_ready_o(aw_ready_o), .aw_id_i(aw_id_i),
    .aw_addr_i(aw_addr_i), .aw_len_i(aw_len_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .w_data_i(w_data_i),
    .w_strb_i(w_strb_i), .w_last_i(w_last_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o),
    .ar_valid_i(ar_valid_i), .ar_ready_o(ar_ready_o), .ar_id_i(ar_id_i),
    .ar_addr_i(ar_addr_i), .ar_len_i(ar_len_i),
    .r_valid_o(r_valid_o), .r_ready_i(r_ready_i), .r_id_o(r_id_o),
    .r_data_o(r_data_o), .r_last_o(r_last_o),
    .ctrl_o(ctrl_o), .flags_i(flags_i)
  );

  // One complete write burst; contend raises AR alongside AW in the grant cycle.
  task automatic do_write(input logic [7:0] id, input logic [63:0] addr,
                          input logic [3:0] len, input logic contend);
    logic [63:0]  exp_addr;
    logic [511:0] wdat;
    exp_addr = addr;
    @(negedge clk_i);
    aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_valid_i = 1'b1;
    ar_valid_i = contend; ar_id_i = 8'h77; ar_addr_i = 64'hDEAD_0000; ar_len_i = 4'd0;
    #1;
    n_cmp++; if (aw_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL aw_ready_grant id=%h: got %b want 1", id, aw_ready_o); end
    if (ar_valid_i) begin
      n_cmp++; if (ar_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL ar_ready_lose id=%h: got %b want 0", id, ar_ready_o); end
    end
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk_i);
      aw_valid_i = 1'b0; ar_valid_i = 1'b0;
      #1;
      n_cmp++; if (ctrl_o.write_request_ctrl.valid !== 1'b1 || ctrl_o.write_request_ctrl.addr !== exp_addr || ctrl_o.write_request_ctrl.id !== id) begin
        n_err++; $display("[TB] FAIL wr_req beat %0d: got v=%b id=%h addr=%h want v=1 id=%h addr=%h", i,
          ctrl_o.write_request_ctrl.valid, ctrl_o.write_request_ctrl.id, ctrl_o.write_request_ctrl.addr, id, exp_addr);
      end
      n_cmp++; if (ctrl_o.read_request_ctrl.valid !== 1'b0 || aw_ready_o !== 1'b0) begin
        n_err++; $display("[TB] FAIL wr_req_excl beat %0d: got rd_req=%b aw_ready=%b want 0 0", i, ctrl_o.read_request_ctrl.valid, aw_ready_o);
      end
      flags_i.write_request_flags.ready = 1'b1;
      @(negedge clk_i);
      flags_i.write_request_flags.ready = 1'b0;
      wdat = {16{32'hA500_0000 + 32'(i)}};
      w_data_i = wdat; w_strb_i = '1; w_last_i = (i == int'(len)); w_valid_i = 1'b1;
      flags_i.write_data_flags.ready = 1'b1;
      #1;
      n_cmp++; if (ctrl_o.write_data_ctrl.valid !== 1'b1 || ctrl_o.write_data_ctrl.last !== 1'b1 || ctrl_o.write_data_ctrl.data !== wdat
                   || ctrl_o.write_data_ctrl.strb !== 64'hFFFF_FFFF_FFFF_FFFF || w_ready_o !== 1'b1) begin
        n_err++; $display("[TB] FAIL wr_data beat %0d: got v=%b last=%b w_ready=%b data_ok=%b want v=1 last=1 w_ready=1 data_ok=1", i,
          ctrl_o.write_data_ctrl.valid, ctrl_o.write_data_ctrl.last, w_ready_o, ctrl_o.write_data_ctrl.data === wdat);
      end
      @(negedge clk_i);
      w_valid_i = 1'b0; flags_i.write_data_flags.ready = 1'b0;
      #1;
      n_cmp++; if (ctrl_o.write_response_ctrl.ready !== 1'b1 || b_valid_o !== 1'b0 || ctrl_o.write_data_ctrl.valid !== 1'b0) begin
        n_err++; $display("[TB] FAIL wr_resp beat %0d: got resp_ready=%b b_valid=%b wd_valid=%b want 1 0 0", i,
          ctrl_o.write_response_ctrl.ready, b_valid_o, ctrl_o.write_data_ctrl.valid);
      end
      flags_i.write_response_flags.valid = 1'b1;
      @(negedge clk_i);
      flags_i.write_response_flags.valid = 1'b0;
      exp_addr = exp_addr + 64'd64;
    end
    #1;
    n_cmp++; if (b_valid_o !== 1'b1 || b_id_o !== id) begin
      n_err++; $display("[TB] FAIL b_resp id=%h: got b_valid=%b b_id=%h want 1 %h", id, b_valid_o, b_id_o, id);
    end
    b_ready_i = 1'b1;
    @(negedge clk_i);
    b_ready_i = 1'b0;
    #1;
    n_cmp++; if (b_valid_o !== 1'b0 || ctrl_o !== '0) begin
      n_err++; $display("[TB] FAIL idle_after_b id=%h: got b_valid=%b ctrl_zero=%b want 0 1", id, b_valid_o, ctrl_o === '0);
    end
  endtask

  // One complete read burst; stall holds r_ready low for 3 cycles on the first beat.
  task automatic do_read(input logic [7:0] id, input logic [63:0] addr, input logic [3:0] len,
                         input logic stall, input logic contend);
    logic [63:0]  exp_addr;
    logic [511:0] rdat;
    exp_addr = addr;
    @(negedge clk_i);
    ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_valid_i = 1'b1;
    aw_valid_i = contend; aw_id_i = 8'h66; aw_addr_i = 64'hBEEF_0000; aw_len_i = 4'd0;
    #1;
    n_cmp++; if (ar_ready_o !== 1'b1) begin n_err++; $display("[TB] FAIL ar_ready_grant id=%h: got %b want 1", id, ar_ready_o); end
    if (aw_valid_i) begin
      n_cmp++; if (aw_ready_o !== 1'b0) begin n_err++; $display("[TB] FAIL aw_ready_lose id=%h: got %b want 0", id, aw_ready_o); end
    end
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk_i);
      ar_valid_i = 1'b0; aw_valid_i = 1'b0;
      #1;
      n_cmp++; if (ctrl_o.read_request_ctrl.valid !== 1'b1 || ctrl_o.read_request_ctrl.addr !== exp_addr || ctrl_o.read_request_ctrl.id !== id
                   || ctrl_o.write_request_ctrl.valid !== 1'b0) begin
        n_err++; $display("[TB] FAIL rd_req beat %0d: got v=%b id=%h addr=%h wr_v=%b want v=1 id=%h addr=%h wr_v=0", i,
          ctrl_o.read_request_ctrl.valid, ctrl_o.read_request_ctrl.id, ctrl_o.read_request_ctrl.addr, ctrl_o.write_request_ctrl.valid, id, exp_addr);
      end
      flags_i.read_request_flags.ready = 1'b1;
      @(negedge clk_i);
      flags_i.read_request_flags.ready = 1'b0;
      rdat = {16{32'hC0DE_0000 + 32'(i)}};
      flags_i.read_data_flags.valid = 1'b1; flags_i.read_data_flags.data = rdat;
      if (stall && i == 0) begin
        for (int s = 0; s < 3; s++) begin
          #1;
          n_cmp++; if (r_valid_o !== 1'b1 || ctrl_o.read_data_ctrl.ready !== 1'b0 || r_data_o !== rdat) begin
            n_err++; $display("[TB] FAIL rd_stall cycle %0d: got r_valid=%b rd_ready=%b data_ok=%b want 1 0 1", s,
              r_valid_o, ctrl_o.read_data_ctrl.ready, r_data_o === rdat);
          end
          @(negedge clk_i);
        end
      end
      r_ready_i = 1'b1;
      #1;
      n_cmp++; if (r_valid_o !== 1'b1 || r_id_o !== id || r_data_o !== rdat || r_last_o !== (i == int'(len))
                   || ctrl_o.read_data_ctrl.ready !== 1'b1) begin
        n_err++; $display("[TB] FAIL r_beat %0d: got v=%b id=%h last=%b rd_ready=%b data_ok=%b want v=1 id=%h last=%b rd_ready=1 data_ok=1", i,
          r_valid_o, r_id_o, r_last_o, ctrl_o.read_data_ctrl.ready, r_data_o === rdat, id, (i == int'(len)));
      end
      @(negedge clk_i);
      r_ready_i = 1'b0; flags_i.read_data_flags.valid = 1'b0; flags_i.read_data_flags.data = '0;
      exp_addr = exp_addr + 64'd64;
    end
    #1;
    n_cmp++; if (r_valid_o !== 1'b0 || ctrl_o !== '0) begin
      n_err++; $display("[TB] FAIL idle_after_r id=%h: got r_valid=%b ctrl_zero=%b want 0 1", id, r_valid_o, ctrl_o === '0);
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (aw_ready_o !== 1'b0 || ar_ready_o !== 1'b0 || w_ready_o !== 1'b0 || b_valid_o !== 1'b0 || r_valid_o !== 1'b0 || ctrl_o !== '0) begin
      n_err++; $display("[TB] FAIL reset_outputs: got aw_r=%b ar_r=%b w_r=%b b_v=%b r_v=%b ctrl_zero=%b want all 0, ctrl_zero=1",
        aw_ready_o, ar_ready_o, w_ready_o, b_valid_o, r_valid_o, ctrl_o === '0);
    end
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    n_cmp++; if (aw_ready_o !== 1'b1 || ar_ready_o !== 1'b1) begin
      n_err++; $display("[TB] FAIL idle_ready: got aw_ready=%b ar_ready=%b want 1 1", aw_ready_o, ar_ready_o);
    end
  endtask

  task automatic test_single_write();
    do_write(8'h12, 64'h1000, 4'd0, 1'b0);
  endtask

  task automatic test_write_burst();
    do_write(8'h34, 64'h2000, 4'd3, 1'b0);
  endtask

  task automatic test_read_burst();
    do_read(8'h05, 64'h3FC0, 4'd1, 1'b1, 1'b0);
  endtask

  // Previous test ended with a read, so a round-robin arbiter favours the write first.
  task automatic test_arbitration();
`ifdef NVDLA_AXI2DBB_RR_ARB_EN
    do_write(8'h31, 64'h5000, 4'd0, 1'b1);
    do_read (8'h21, 64'h6000, 4'd0, 1'b0, 1'b1);
    do_write(8'h32, 64'h5040, 4'd0, 1'b1);
    do_read (8'h22, 64'h6040, 4'd0, 1'b0, 1'b1);
`else
    do_write(8'h31, 64'h5000, 4'd0, 1'b1);
    do_write(8'h32, 64'h5040, 4'd0, 1'b1);
    do_read (8'h21, 64'h6000, 4'd0, 1'b0, 1'b0);
`endif
  endtask

  task automatic test_addr_wrap();
    do_write(8'h7E, 64'hFFFF_FFFF_FFFF_FFC0, 4'd1, 1'b0);
    do_read (8'h7F, 64'hFFFF_FFFF_FFFF_FFC0, 4'd1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_burst();
    @(negedge clk_i);
    aw_id_i = 8'h44; aw_addr_i = 64'h8000; aw_len_i = 4'd3; aw_valid_i = 1'b1;
    @(negedge clk_i);
    aw_valid_i = 1'b0; flags_i.write_request_flags.ready = 1'b1;
    @(negedge clk_i);
    flags_i.write_request_flags.ready = 1'b0;
    w_data_i = {16{32'h5A5A_0001}}; w_strb_i = '1; w_valid_i = 1'b1; flags_i.write_data_flags.ready = 1'b1;
    #1;
    n_cmp++; if (ctrl_o.write_data_ctrl.valid !== 1'b1) begin
      n_err++; $display("[TB] FAIL pre_reset_wr_data: got %b want 1", ctrl_o.write_data_ctrl.valid);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (ctrl_o !== '0 || w_ready_o !== 1'b0 || aw_ready_o !== 1'b0 || b_valid_o !== 1'b0 || r_valid_o !== 1'b0) begin
      n_err++; $display("[TB] FAIL mid_burst_reset: got ctrl_zero=%b w_ready=%b aw_ready=%b b_valid=%b r_valid=%b want 1 0 0 0 0",
        ctrl_o === '0, w_ready_o, aw_ready_o, b_valid_o, r_valid_o);
    end
    w_valid_i = 1'b0; flags_i.write_data_flags.ready = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    do_write(8'h45, 64'h9000, 4'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_write_burst();
    test_read_burst();
    test_arbitration();
    test_addr_wrap();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
